// File: rtl/ucounter_seq_pkg.sv
// ucounter_seq_pkg: opcodes, status codes and FSM encoding for the counter sequencer
package ucounter_seq_pkg;
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STEP  = 2'b01;
  localparam logic [1:0] OP_RUNTO = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_WRAPPED = 2'b01;
  localparam logic [1:0] ST_STOPPED = 2'b10;
  localparam logic [1:0] ST_ABORTED = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/seq_step_cnt.sv
// seq_step_cnt: loadable down-counter with saturating decrement and zero flag
module seq_step_cnt #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  assign o_zero = r_cnt == '0;
  always_ff @(posedge clk)
    r_cnt <= reset ? '0 : i_load ? i_val : (i_dec && !o_zero) ? r_cnt - 1'b1 : r_cnt;
endmodule

// File: rtl/ucounter_seq.sv
// ucounter_seq: one-command-at-a-time sequencer driving the ucounter16 control pins
module ucounter_seq
  import ucounter_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RUN_LIMIT = 65536
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             cmd_dir,
  input  logic             cmd_wrap,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  input  logic             cnt_overflow,
  output logic             ctr_load_n,
  output logic [WIDTH-1:0] ctr_preld,
  output logic             ctr_updown,
  output logic             ctr_wrapstop_n,
  output logic             ctr_carry_in,
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_status
);
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_arg;
  logic             r_dir, r_wrap, r_wrapped;
  logic [1:0]       r_status, w_status_nxt;
  logic             w_accept, w_match, w_zero, w_ovf, w_stop;
  logic [WIDTH:0]   w_load_val;
  assign w_accept = cmd_valid & cmd_ready;
  assign w_match  = cnt_value == r_arg;
  assign w_ovf    = cnt_overflow & ctr_carry_in;
  assign w_stop   = w_ovf & ~r_wrap;
  // STEP ends on the cycle the remaining count is zero, so preload n-1; RUN gates enable once the limit is spent
  assign w_load_val = cmd_op == OP_RUNTO ? (WIDTH+1)'(RUN_LIMIT) : {1'b0, cmd_arg} - 1'b1;
  assign cmd_ready      = r_state == S_IDLE && !reset;
  assign busy           = r_state != S_IDLE;
  assign done           = r_state == S_DONE;
  assign done_status    = r_status;
  assign ctr_load_n     = !(r_state == S_LOAD && !abort);
  assign ctr_preld      = r_arg;
  assign ctr_updown     = r_dir;
  assign ctr_wrapstop_n = r_wrap;
  assign ctr_carry_in   = !abort && (r_state == S_STEP || (r_state == S_RUN && !w_match && !w_zero));
  seq_step_cnt #(.W(WIDTH + 1)) u_step_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept),
    .i_val  (w_load_val),
    .i_dec  (ctr_carry_in),
    .o_zero (w_zero)
  );
  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    case (r_state)
      S_IDLE: begin
        w_status_nxt = ST_OK;
        if (w_accept)
          w_state_nxt = cmd_op == OP_LOAD ? S_LOAD : cmd_op == OP_RUNTO ? S_RUN :
                        (cmd_op == OP_STEP && cmd_arg != '0) ? S_STEP : S_DONE;
      end
      S_LOAD: begin
        w_state_nxt  = S_DONE;
        w_status_nxt = abort ? ST_ABORTED : ST_OK;
      end
      S_STEP: begin
        w_status_nxt = abort ? ST_ABORTED : w_stop ? ST_STOPPED : (r_wrapped || w_ovf) ? ST_WRAPPED : ST_OK;
        if (abort || w_stop || w_zero) w_state_nxt = S_DONE;
      end
      S_RUN: begin
        w_status_nxt = abort ? ST_ABORTED : w_match ? (r_wrapped ? ST_WRAPPED : ST_OK) :
                       w_stop ? ST_STOPPED : ST_ABORTED;
        if (abort || w_match || w_stop || w_zero) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_arg     <= '0;
      r_dir     <= 1'b1;
      r_wrap    <= 1'b1;
      r_wrapped <= 1'b0;
      r_status  <= ST_OK;
    end else begin
      r_state   <= w_state_nxt;
      r_wrapped <= w_accept ? 1'b0 : r_wrapped | (w_ovf & r_wrap);
      if (w_state_nxt == S_DONE && r_state != S_DONE) r_status <= w_status_nxt;
      if (w_accept) begin
        r_arg  <= cmd_arg;
        r_dir  <= cmd_dir;
        r_wrap <= cmd_wrap;
      end
    end
  end
endmodule
